// File: rtl/ln_pkg.sv
// Shared types and constants for the image loader and processing element.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ln_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int CLASS_W = 11;

  // Number of bytes in one image.
  function automatic int image_bytes(input int w, input int h, input int c);
    return w * h * c;
  endfunction

endpackage

// File: rtl/image_loader_rom_lat_pipe.sv
// Valid-tag shift register that tracks ROM reads in flight.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; every tag moves one stage per cycle, flush empties it.
module rom_lat_pipe
  import ln_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic flush,
  input  logic in_vld,
  output logic out_vld
);

  logic [DEPTH-1:0] tag_q;

  // Advance every tag one stage per cycle; flush clears all stages
  always_ff @(posedge clk) begin
    if (flush) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_vld = tag_q[DEPTH-1];

endmodule

// File: rtl/image_loader.sv
// Loads one image from the ROM into the flat pixel bus, runs the PE, latches its class.
// Latency: start to first pe_enable is N+ROM_LAT+1 cycles; class_valid one cycle after pe_done.
// Backpressure: start is ignored while busy and in the class_valid cycle; nothing is queued.
module image_loader
  import ln_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int HEIGHT  = 32,
  parameter  int CHANNEL = 3,
  parameter  int ADDR_W  = 21,
  parameter  int ROM_LAT = 1,
  localparam int N       = image_bytes(WIDTH, HEIGHT, CHANNEL),
  localparam int PIX_W   = N * 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [7:0]         rom_data,
  output logic [PIX_W-1:0]   pixel,
  output logic               pe_enable,
  input  logic               pe_done,
  input  logic [CLASS_W-1:0] pe_class,
  output logic [CLASS_W-1:0] class_out,
  output logic               class_valid,
  output logic               busy
);

  // One extra bit so the counters can hold N even when N == 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_cnt_nxt;
  logic             tag_vld;
  logic             accept;

  // A start is taken only from IDLE, and not in the cycle that reports a class.
  assign accept     = (state == IDLE) && start && !class_valid;
  // Count including a byte landing this cycle, so RUN begins right after the last write.
  assign wr_cnt_nxt = wr_cnt + CNT_W'(tag_vld);

  rom_lat_pipe #(
    .DEPTH (ROM_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .flush   (!reset),
    .in_vld  (rom_en),
    .out_vld (tag_vld)
  );

  // Sequencer: issue N reads, wait for them to land, then run the PE until done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      issue_cnt   <= '0;
      pe_enable   <= 1'b0;
      class_out   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= FETCH;
            busy      <= 1'b1;
            rom_en    <= 1'b1;
            rom_addr  <= '0;
            issue_cnt <= '0;
          end
        end
        FETCH: begin
          if (issue_cnt == CNT_W'(N - 1)) begin
            rom_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            rom_addr  <= ADDR_W'(issue_cnt + CNT_W'(1));
          end
        end
        DRAIN: begin
          if (wr_cnt_nxt == CNT_W'(N)) begin
            state     <= RUN;
            pe_enable <= 1'b1;
          end
        end
        RUN: begin
          if (pe_done) begin
            class_out   <= pe_class;
            class_valid <= 1'b1;
            pe_enable   <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture: write each returning byte at the write counter, in issue order
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt <= '0;
      pixel  <= '0;
    end else begin
      if (accept) begin
        wr_cnt <= '0;
      end else if (tag_vld) begin
        wr_cnt <= wr_cnt_nxt;
      end
      for (int k = 0; k < N; k++) begin
        if (tag_vld && (wr_cnt == CNT_W'(k))) begin
          pixel[k*8 +: 8] <= rom_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: two instances (ROM_LAT 1 and 3), timeline model, per-cycle compare.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_image_loader;

  localparam int N      = 12;
  localparam int ADDR_W = 5;
  localparam logic [95:0] PIX_EXP = 96'hAEAFACAD_A2A3A0A1_A6A7A4A5;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  start;
  logic [1:0]  pe_done;
  logic [10:0] pe_class   [2];
  logic [1:0]  rom_en;
  logic [ADDR_W-1:0] rom_addr [2];
  logic [7:0]  rom_data   [2];
  logic [95:0] pixel      [2];
  logic [1:0]  pe_en;
  logic [10:0] class_out  [2];
  logic [1:0]  class_valid;
  logic [1:0]  busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  image_loader #(.WIDTH(2), .HEIGHT(2), .CHANNEL(3), .ADDR_W(ADDR_W), .ROM_LAT(1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .start(start[0]), .rom_en(rom_en[0]), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]), .pixel(pixel[0]), .pe_enable(pe_en[0]), .pe_done(pe_done[0]),
    .pe_class(pe_class[0]), .class_out(class_out[0]), .class_valid(class_valid[0]), .busy(busy[0])
  );

  image_loader #(.WIDTH(2), .HEIGHT(2), .CHANNEL(3), .ADDR_W(ADDR_W), .ROM_LAT(3)) dut1 (
    .clk(clk), .reset(rst_n[1]), .start(start[1]), .rom_en(rom_en[1]), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]), .pixel(pixel[1]), .pe_enable(pe_en[1]), .pe_done(pe_done[1]),
    .pe_class(pe_class[1]), .class_out(class_out[1]), .class_valid(class_valid[1]), .busy(busy[1])
  );

  // ROM models: data = addr ^ 8'hA5, delivered ROM_LAT cycles after the read
  logic [7:0] rp [2][4];
  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      rp[d][0] <= rom_en[d] ? ({3'b000, rom_addr[d]} ^ 8'hA5) : 8'h00;
      for (int j = 1; j < 4; j++) rp[d][j] <= rp[d][j-1];
    end
  end
  assign rom_data[0] = rp[0][0];
  assign rom_data[1] = rp[1][2];

  // Timeline model: everything follows from the edge at which a load was accepted.
  int          lat [2] = '{1, 3};
  int          edge_n = -1;
  int          e0 [2] = '{-1, -1};
  logic [7:0]  mpix [2][N];
  logic [10:0] mcls [2];
  bit          mcv [2];
  int          maddr [2];
  bit          act_o [2];
  bit          pe_o [2];
  bit          cv_o [2];

  function automatic bit m_act(input int d);
    return e0[d] >= 0;
  endfunction
  function automatic bit m_rom_en(input int d);
    return m_act(d) && (edge_n - e0[d]) < N;
  endfunction
  function automatic bit m_pe(input int d);
    return m_act(d) && (edge_n - e0[d]) >= N + lat[d];
  endfunction
  function automatic logic [95:0] m_pix(input int d);
    logic [95:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*8 +: 8] = mpix[d][k];
    return p;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      act_o[d] = m_act(d);
      pe_o[d]  = m_pe(d);
      cv_o[d]  = mcv[d];
    end
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        e0[d] = -1;
        for (int k = 0; k < N; k++) mpix[d][k] = 8'h00;
        mcls[d]  = '0;
        mcv[d]   = 1'b0;
        maddr[d] = 0;
      end else begin
        mcv[d] = 1'b0;
        if (act_o[d]) begin
          int k;
          k = edge_n - e0[d] - lat[d] - 1;
          if (k >= 0 && k < N) mpix[d][k] = 8'(k) ^ 8'hA5;
        end
        if (act_o[d] && pe_o[d] && pe_done[d]) begin
          mcls[d] = pe_class[d];
          mcv[d]  = 1'b1;
          e0[d]   = -1;
        end else if (!act_o[d] && start[d] && !cv_o[d]) begin
          e0[d] = edge_n;
        end
        if (m_rom_en(d)) maddr[d] = edge_n - e0[d];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d rom_en", d), rom_en[d], m_rom_en(d));
        chk($sformatf("d%0d rom_addr", d), rom_addr[d], maddr[d]);
        chk($sformatf("d%0d pe_enable", d), pe_en[d], m_pe(d));
        chk($sformatf("d%0d busy", d), busy[d], m_act(d));
        chk($sformatf("d%0d class_out", d), class_out[d], mcls[d]);
        chk($sformatf("d%0d class_valid", d), class_valid[d], mcv[d]);
        chk($sformatf("d%0d pixel", d), pixel[d], m_pix(d));
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 with the accept edge index.
  task automatic pulse_start(input int d, output int edge0);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    edge0 = edge_n;
  endtask

  task automatic wait_pe(input int d, input int edge0, output int cyc, output int en_cnt,
                         output int cv_cnt);
    cyc = -1;
    en_cnt = 0;
    cv_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (rom_en[d]) en_cnt++;
      if (class_valid[d]) cv_cnt++;
      if (pe_en[d]) begin
        cyc = edge_n - edge0 + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_img(input int d, input logic [10:0] cls);
    pe_done[d]  = 1'b1;
    pe_class[d] = cls;
    @(negedge clk);
    pe_done[d] = 1'b0;
    chk("class_valid pulse", class_valid[d], 1'b1);
    chk("class_out latched", class_out[d], cls);
    chk("pe_enable dropped", pe_en[d], 1'b0);
    chk("busy dropped", busy[d], 1'b0);
    @(negedge clk);
    chk("class_valid width", class_valid[d], 1'b0);
  endtask

  initial begin
    int e, cyc, en, cv, first;
    rst_n = 2'b00;
    start = 2'b00;
    pe_done = 2'b00;
    pe_class[0] = '0;
    pe_class[1] = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", busy[0], 1'b0);
    chk("reset pixel", pixel[0], 96'h0);
    chk("reset class_out", class_out[1], 11'h0);
    rst_n = 2'b11;
    @(negedge clk);

    // Load with ROM_LAT=1, then finish with class 3
    pulse_start(0, e);
    wait_pe(0, e, cyc, en, cv);
    chk("lat1 pe_enable rise cycle", cyc, 14);
    chk("lat1 read count", en, 12);
    chk("lat1 pixel", pixel[0], PIX_EXP);
    finish_img(0, 11'h3);

    // Load with ROM_LAT=3
    pulse_start(1, e);
    wait_pe(1, e, cyc, en, cv);
    chk("lat3 pe_enable rise cycle", cyc, 16);
    chk("lat3 pixel", pixel[1], PIX_EXP);
    finish_img(1, 11'h0FF);

    // Extra start pulses during a load are ignored
    pulse_start(0, e);
    en = 0;
    first = -1;
    for (int c = 1; c <= 16; c++) begin
      if (rom_en[0]) en++;
      if (pe_en[0] && first < 0) first = c;
      start[0] = (c == 5 || c == 15);
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("ignored start read count", en, 12);
    chk("ignored start pe rise", first, 14);
    finish_img(0, 11'h2A);

    // Reset during FETCH abandons the image
    pulse_start(0, e);
    repeat (6) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("midreset rom_en", rom_en[0], 1'b0);
    chk("midreset rom_addr", rom_addr[0], 5'd0);
    chk("midreset pixel", pixel[0], 96'h0);
    chk("midreset class_out", class_out[0], 11'h0);
    chk("midreset busy", busy[0], 1'b0);
    chk("midreset pe_enable", pe_en[0], 1'b0);
    pulse_start(0, e);
    wait_pe(0, e, cyc, en, cv);
    chk("reload pixel", pixel[0], PIX_EXP);
    chk("reload no spurious class_valid", cv, 0);
    finish_img(0, 11'h2B);

    // pe_done outside RUN is ignored; back-to-back images with classes 5 and 9
    pe_done[0] = 1'b1;
    pe_class[0] = 11'h7FF;
    repeat (3) @(negedge clk);
    chk("idle pe_done class_valid", class_valid[0], 1'b0);
    chk("idle pe_done class_out", class_out[0], 11'h2B);
    pulse_start(0, e);
    repeat (4) @(negedge clk);
    pe_done[0] = 1'b0;
    chk("fetch pe_done busy", busy[0], 1'b1);
    chk("fetch pe_done class_valid", class_valid[0], 1'b0);
    wait_pe(0, e, cyc, en, cv);
    finish_img(0, 11'h5);
    pulse_start(0, e);
    wait_pe(0, e, cyc, en, cv);
    chk("back-to-back pe rise", cyc, 14);
    finish_img(0, 11'h9);

    // Random traffic on both instances, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst_n[d]    = ($urandom_range(0, 199) != 0);
        start[d]    = ($urandom_range(0, 7) == 0);
        pe_done[d]  = ($urandom_range(0, 3) == 0);
        pe_class[d] = 11'($urandom);
      end
      @(negedge clk);
    end
    rst_n = 2'b11;
    start = 2'b00;
    pe_done = 2'b00;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
